// File: rtl/sdram_arbiter_if.sv
// Signal bundle between sdram_arbiter, its two clients and the SDRAM controller command port.
// The arbiter connects through the slave modport; clients and the controller use the master view.
interface sdram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              c0_req;
    logic              c1_req;
    logic              c0_we;
    logic              c1_we;
    logic [ADDR_W-1:0] c0_addr;
    logic [ADDR_W-1:0] c1_addr;
    logic [DATA_W-1:0] c0_wdata;
    logic [DATA_W-1:0] c1_wdata;
    logic              c0_ack;
    logic              c1_ack;
    logic              c0_rvalid;
    logic              c1_rvalid;
    logic              c0_err;
    logic              c1_err;
    logic [DATA_W-1:0] rdata;

    logic              mem_busy;
    logic              mem_WrReq;
    logic              mem_RdReq;
    logic              mem_WrGnt;
    logic              mem_RdGnt;
    logic [ADDR_W-1:0] mem_WrAddr;
    logic [ADDR_W-1:0] mem_RdAddr;
    logic [DATA_W-1:0] mem_WrData;
    logic [DATA_W-1:0] mem_RdData;
    logic              mem_RdDataValid;

    modport slave (
        input  c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata,
        output c0_ack, c1_ack, c0_rvalid, c1_rvalid, c0_err, c1_err, rdata,
        input  mem_busy, mem_WrGnt, mem_RdGnt, mem_RdData, mem_RdDataValid,
        output mem_WrReq, mem_RdReq, mem_WrAddr, mem_RdAddr, mem_WrData
    );

    modport master (
        output c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata,
        input  c0_ack, c1_ack, c0_rvalid, c1_rvalid, c0_err, c1_err, rdata,
        output mem_busy, mem_WrGnt, mem_RdGnt, mem_RdData, mem_RdDataValid,
        input  mem_WrReq, mem_RdReq, mem_WrAddr, mem_RdAddr, mem_WrData
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command port between a CPU client (0)
// and a display-fetch client (1); one transaction in flight, each guarded by a timeout.
module sdram_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           notRst,
    sdram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_WR = 2'd2,
        WAIT_RD = 2'd3
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic              last_q, last_d;
    logic [7:0]        timer_q, timer_d;
    logic              busy_seen_q, busy_seen_d;
    logic              rdv_prev_q, rdv_prev_d;
    logic              c0_ack_q, c0_ack_d;
    logic              c1_ack_q, c1_ack_d;
    logic              c0_rvalid_q, c0_rvalid_d;
    logic              c1_rvalid_q, c1_rvalid_d;
    logic              c0_err_q, c0_err_d;
    logic              c1_err_q, c1_err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wr_req_q, wr_req_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              any_req_s;
    logic              win_s;
    logic              win_we_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;
    logic              abort_s;

    // Winner selection: a lone requester wins, a tie goes to the client not served last.
    always_comb begin
        any_req_s = bus.c0_req | bus.c1_req;
        if (bus.c0_req && bus.c1_req) begin
            win_s = ~last_q;
        end else begin
            win_s = bus.c1_req;
        end
        win_we_s    = win_s ? bus.c1_we    : bus.c0_we;
        win_addr_s  = win_s ? bus.c1_addr  : bus.c0_addr;
        win_wdata_s = win_s ? bus.c1_wdata : bus.c0_wdata;
    end

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        last_d      = last_q;
        timer_d     = timer_q;
        busy_seen_d = busy_seen_q;
        rdv_prev_d  = bus.mem_RdDataValid;
        c0_ack_d    = 1'b0;
        c1_ack_d    = 1'b0;
        c0_rvalid_d = 1'b0;
        c1_rvalid_d = 1'b0;
        c0_err_d    = 1'b0;
        c1_err_d    = 1'b0;
        rdata_d     = rdata_q;
        wr_req_d    = wr_req_q;
        rd_req_d    = rd_req_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        wr_data_d   = wr_data_q;
        abort_s     = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = 8'd0;
                if (any_req_s && !bus.mem_busy) begin
                    owner_d   = win_s;
                    last_d    = win_s;
                    we_d      = win_we_s;
                    wr_addr_d = win_addr_s;
                    rd_addr_d = win_addr_s;
                    wr_data_d = win_wdata_s;
                    wr_req_d  = win_we_s;
                    rd_req_d  = ~win_we_s;
                    c0_ack_d  = ~win_s;
                    c1_ack_d  = win_s;
                    state_d   = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                // A grant on the timeout edge still counts: it is checked first.
                if ((we_q && bus.mem_WrGnt) || (!we_q && bus.mem_RdGnt)) begin
                    wr_req_d    = 1'b0;
                    rd_req_d    = 1'b0;
                    timer_d     = 8'd0;
                    busy_seen_d = 1'b0;
                    state_d     = we_q ? WAIT_WR : WAIT_RD;
                end else if (timer_q == TIMER_LAST) begin
                    abort_s = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            WAIT_WR: begin
                if (busy_seen_q && !bus.mem_busy) begin
                    timer_d = 8'd0;
                    state_d = IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    abort_s = 1'b1;
                end else begin
                    timer_d     = timer_q + 8'd1;
                    busy_seen_d = busy_seen_q | bus.mem_busy;
                end
            end
            WAIT_RD: begin
                // Valid may be left high by the controller, so only a rising edge completes.
                if (!rdv_prev_q && bus.mem_RdDataValid) begin
                    rdata_d     = bus.mem_RdData;
                    c0_rvalid_d = ~owner_q;
                    c1_rvalid_d = owner_q;
                    timer_d     = 8'd0;
                    state_d     = IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    abort_s = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_s) begin
            wr_req_d = 1'b0;
            rd_req_d = 1'b0;
            c0_err_d = ~owner_q;
            c1_err_d = owner_q;
            timer_d  = 8'd0;
            state_d  = IDLE;
        end else begin
            c0_err_d = 1'b0;
            c1_err_d = 1'b0;
        end
    end

    // State and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!notRst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            last_q      <= 1'b1;
            timer_q     <= 8'd0;
            busy_seen_q <= 1'b0;
            rdv_prev_q  <= 1'b0;
            c0_ack_q    <= 1'b0;
            c1_ack_q    <= 1'b0;
            c0_rvalid_q <= 1'b0;
            c1_rvalid_q <= 1'b0;
            c0_err_q    <= 1'b0;
            c1_err_q    <= 1'b0;
            rdata_q     <= {DATA_W{1'b0}};
            wr_req_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_addr_q   <= {ADDR_W{1'b0}};
            rd_addr_q   <= {ADDR_W{1'b0}};
            wr_data_q   <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            last_q      <= last_d;
            timer_q     <= timer_d;
            busy_seen_q <= busy_seen_d;
            rdv_prev_q  <= rdv_prev_d;
            c0_ack_q    <= c0_ack_d;
            c1_ack_q    <= c1_ack_d;
            c0_rvalid_q <= c0_rvalid_d;
            c1_rvalid_q <= c1_rvalid_d;
            c0_err_q    <= c0_err_d;
            c1_err_q    <= c1_err_d;
            rdata_q     <= rdata_d;
            wr_req_q    <= wr_req_d;
            rd_req_q    <= rd_req_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus.c0_ack     = c0_ack_q;
    assign bus.c1_ack     = c1_ack_q;
    assign bus.c0_rvalid  = c0_rvalid_q;
    assign bus.c1_rvalid  = c1_rvalid_q;
    assign bus.c0_err     = c0_err_q;
    assign bus.c1_err     = c1_err_q;
    assign bus.rdata      = rdata_q;
    assign bus.mem_WrReq  = wr_req_q;
    assign bus.mem_RdReq  = rd_req_q;
    assign bus.mem_WrAddr = wr_addr_q;
    assign bus.mem_RdAddr = rd_addr_q;
    assign bus.mem_WrData = wr_data_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus randomized rounds, each cycle compared
// against a transaction-timeline model of the arbitration, grant, completion and timeout rules.
module tb_sdram_arbiter;
    localparam int AW      = 12;
    localparam int DW      = 16;
    localparam int TIMEOUT = 8;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            g;       // grant on the g-th edge after acceptance, 0 = never
        int            lat;     // write: busy cycles; read: edges from grant to valid rise
        logic          sticky;  // read leaves RdDataValid high afterwards
        logic          noise;   // toggle the non-matching grant while waiting
    } txn_t;

    logic clk;
    logic notRst;
    int   checks;
    int   failures;
    int   last_m;
    logic rdv_lvl;
    logic [DW-1:0] mem_m [logic [AW-1:0]];

    sdram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .notRst (notRst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // Expected {ack0,ack1,rv0,rv1,err0,err1,WrReq,RdReq}; kind 1=ack 2=rvalid 3=err.
    function automatic logic [7:0] ex(input int who, input int kind, input logic wr, input logic rd);
        logic [7:0] v;
        v = 8'd0;
        case (kind)
            1:       v[7-who] = 1'b1;
            2:       v[5-who] = 1'b1;
            3:       v[3-who] = 1'b1;
            default: v = 8'd0;
        endcase
        v[1] = wr;
        v[0] = rd;
        return v;
    endfunction

    function automatic logic [7:0] obs();
        return {bus.c0_ack, bus.c1_ack, bus.c0_rvalid, bus.c1_rvalid,
                bus.c0_err, bus.c1_err, bus.mem_WrReq, bus.mem_RdReq};
    endfunction

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (mem_m.exists(a)) begin
            return mem_m[a];
        end
        return 16'(a) ^ 16'hA5A5;
    endfunction

    function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input int g, input int lat, input logic sticky);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.g = g; t.lat = lat;
        t.sticky = sticky; t.noise = 1'b0;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we     = 1'($urandom_range(0, 1));
        t.addr   = 12'($urandom_range(0, 15));
        t.wdata  = 16'($urandom);
        t.g      = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TIMEOUT);
        if (t.we) begin
            t.lat = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 9) - 8 * $urandom_range(0, 1)
                                                : $urandom_range(1, 7);
        end else begin
            t.lat = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 10) : $urandom_range(1, TIMEOUT);
        end
        t.sticky = 1'($urandom_range(0, 1));
        t.noise  = 1'($urandom_range(0, 1));
        return t;
    endfunction

    task automatic step(input logic [7:0] exp, input string tag);
        @(posedge clk);
        #1;
        check_val(tag, {24'd0, obs()}, {24'd0, exp});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_pulses"}, {24'd0, obs()}, 32'd0);
        check_val({tag, "_rdata"}, {16'd0, bus.rdata}, 32'd0);
        check_val({tag, "_addr"}, {8'd0, bus.mem_WrAddr, bus.mem_RdAddr}, 32'd0);
        check_val({tag, "_wdata"}, {16'd0, bus.mem_WrData}, 32'd0);
    endtask

    // One transaction for client w, from acceptance through grant and completion or timeout.
    task automatic serve(input int w, input txn_t t);
        bit granted;
        int d;
        granted = (t.g >= 1) && (t.g <= TIMEOUT);
        step(ex(w, 1, t.we, !t.we), "accept");
        if (t.we) begin
            check_val("wr_addr", {20'd0, bus.mem_WrAddr}, {20'd0, t.addr});
            check_val("wr_data", {16'd0, bus.mem_WrData}, {16'd0, t.wdata});
        end else begin
            check_val("rd_addr", {20'd0, bus.mem_RdAddr}, {20'd0, t.addr});
        end
        if (w == 0) bus.c0_req = 1'b0; else bus.c1_req = 1'b0;
        last_m = w;

        for (int k = 1; k <= TIMEOUT; k++) begin
            if (k == t.g) begin
                bus.mem_WrGnt = t.we;
                bus.mem_RdGnt = !t.we;
                step(ex(w, 0, 1'b0, 1'b0), "grant");
                break;
            end else begin
                bus.mem_WrGnt = !t.we && t.noise && 1'($urandom_range(0, 1));
                bus.mem_RdGnt = t.we && t.noise && 1'($urandom_range(0, 1));
                if (k == TIMEOUT) step(ex(w, 3, 1'b0, 1'b0), "gnt_timeout");
                else              step(ex(w, 0, t.we, !t.we), "issue_hold");
            end
        end
        bus.mem_WrGnt = 1'b0;
        bus.mem_RdGnt = 1'b0;
        if (!granted) return;

        if (t.we) begin
            mem_m[t.addr] = t.wdata;
            for (int k = 1; k <= TIMEOUT; k++) begin
                bus.mem_busy = (k <= t.lat);
                if (t.lat >= 1 && k == t.lat + 1) begin
                    step(ex(w, 0, 1'b0, 1'b0), "wr_done");
                    break;
                end else if (k == TIMEOUT) begin
                    step(ex(w, 3, 1'b0, 1'b0), "wr_timeout");
                end else begin
                    step(ex(w, 0, 1'b0, 1'b0), "wr_wait");
                end
            end
            bus.mem_busy = 1'b0;
        end else begin
            d = t.lat;
            if (rdv_lvl && d < 2) d = 2;
            for (int k = 1; k <= TIMEOUT; k++) begin
                if (k == d) begin
                    bus.mem_RdDataValid = 1'b1;
                    bus.mem_RdData      = mem_val(t.addr);
                    step(ex(w, 2, 1'b0, 1'b0), "rd_done");
                    check_val("rdata", {16'd0, bus.rdata}, {16'd0, mem_val(t.addr)});
                    break;
                end else begin
                    bus.mem_RdDataValid = rdv_lvl && (k < d - 1);
                    bus.mem_RdData      = 16'($urandom);
                    if (k == TIMEOUT) step(ex(w, 3, 1'b0, 1'b0), "rd_timeout");
                    else              step(ex(w, 0, 1'b0, 1'b0), "rd_wait");
                end
            end
            if (d <= TIMEOUT) begin
                rdv_lvl = t.sticky;
            end else begin
                rdv_lvl = 1'b0;
            end
            bus.mem_RdDataValid = rdv_lvl;
        end
    endtask

    task automatic run_round(input bit r0, input bit r1, input txn_t t0, input txn_t t1, input int hold);
        int first;
        bus.c0_we = t0.we; bus.c0_addr = t0.addr; bus.c0_wdata = t0.wdata;
        bus.c1_we = t1.we; bus.c1_addr = t1.addr; bus.c1_wdata = t1.wdata;
        bus.c0_req = r0;
        bus.c1_req = r1;
        if (hold > 0) begin
            bus.mem_busy = 1'b1;
            for (int i = 0; i < hold; i++) step(8'd0, "busy_hold");
            bus.mem_busy = 1'b0;
        end
        first = (r0 && r1) ? ((last_m == 1) ? 0 : 1) : (r1 ? 1 : 0);
        serve(first, (first == 0) ? t0 : t1);
        if (r0 && r1) serve(1 - first, (first == 0) ? t1 : t0);
    endtask

    initial begin
        txn_t a;
        txn_t b;
        int   r;
        int   hold;
        checks = 0; failures = 0; last_m = 1; rdv_lvl = 1'b0;
        notRst = 1'b0;
        bus.c0_req = 1'b0; bus.c1_req = 1'b0; bus.c0_we = 1'b0; bus.c1_we = 1'b0;
        bus.c0_addr = 12'd0; bus.c1_addr = 12'd0; bus.c0_wdata = 16'd0; bus.c1_wdata = 16'd0;
        bus.mem_busy = 1'b0; bus.mem_WrGnt = 1'b0; bus.mem_RdGnt = 1'b0;
        bus.mem_RdData = 16'd0; bus.mem_RdDataValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        notRst = 1'b1;

        // Tie from reset: c0 first, then c1; a second tie repeats that order.
        a = mk(1'b1, 12'h010, 16'hAAAA, 1, 2, 1'b0);
        b = mk(1'b1, 12'h020, 16'h5555, 1, 2, 1'b0);
        run_round(1'b1, 1'b1, a, b, 0);
        run_round(1'b1, 1'b1, a, b, 0);

        mem_m[12'h123] = 16'hBEEF;
        run_round(1'b1, 1'b0, mk(1'b0, 12'h123, 16'h0, 2, 4, 1'b0), b, 0);

        // Sticky RdDataValid across two reads.
        mem_m[12'h001] = 16'h1111;
        mem_m[12'h002] = 16'h2222;
        run_round(1'b1, 1'b0, mk(1'b0, 12'h001, 16'h0, 1, 3, 1'b1), b, 0);
        run_round(1'b0, 1'b1, a, mk(1'b0, 12'h002, 16'h0, 2, 5, 1'b0), 0);

        // c1 read never granted, then c0 is accepted.
        run_round(1'b0, 1'b1, a, mk(1'b0, 12'h030, 16'h0, 0, 3, 1'b0), 0);
        run_round(1'b1, 1'b0, mk(1'b1, 12'h031, 16'h1234, 3, 2, 1'b0), b, 0);

        // Busy hold-off for 10 cycles.
        run_round(1'b1, 1'b0, mk(1'b0, 12'h010, 16'h0, 1, 2, 1'b0), b, 10);

        // Boundary latencies: grant on the timeout edge, completion on the timeout edge.
        run_round(1'b1, 1'b0, mk(1'b0, 12'h020, 16'h0, TIMEOUT, TIMEOUT, 1'b0), b, 0);
        run_round(1'b0, 1'b1, a, mk(1'b1, 12'h040, 16'h4444, 2, TIMEOUT - 1, 1'b0), 0);
        run_round(1'b0, 1'b1, a, mk(1'b1, 12'h041, 16'h4545, 2, 0, 1'b0), 0);

        for (int i = 0; i < 250; i++) begin
            r    = $urandom_range(1, 3);
            a    = rand_txn();
            b    = rand_txn();
            hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
            run_round(1'(r), 1'(r >> 1), a, b, hold);
        end

        // Reset while waiting for read data: silent abort.
        bus.mem_RdDataValid = 1'b0;
        rdv_lvl = 1'b0;
        bus.c0_req = 1'b1; bus.c0_we = 1'b0; bus.c0_addr = 12'h055;
        step(ex(0, 1, 1'b0, 1'b1), "mr_accept");
        bus.c0_req = 1'b0;
        bus.mem_RdGnt = 1'b1;
        step(8'd0, "mr_grant");
        bus.mem_RdGnt = 1'b0;
        step(8'd0, "mr_wait");
        notRst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_reset");
        notRst = 1'b1;
        bus.mem_RdDataValid = 1'b1;
        bus.mem_RdData = 16'h7777;
        for (int i = 0; i < 12; i++) step(8'd0, "mr_after");
        bus.mem_RdDataValid = 1'b0;
        last_m = 1;
        run_round(1'b1, 1'b1, mk(1'b0, 12'h001, 16'h0, 1, 2, 1'b0),
                  mk(1'b1, 12'h003, 16'h3333, 1, 1, 1'b0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
